// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU datapath blocks: default address/data widths,
// the opcode bit that marks a two-byte instruction, and the fetch-stage state
// encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int CPU_ADDR_W      = 8;
  localparam int CPU_DATA_W      = 8;
  localparam int CPU_LONG_OP_BIT = 7;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_REQ_OP   = 4'd1,
    ST_WAIT_OP  = 4'd2,
    ST_INC_OP   = 4'd3,
    ST_REQ_ARG  = 4'd4,
    ST_WAIT_ARG = 4'd5,
    ST_INC_ARG  = 4'd6,
    ST_OUT      = 4'd7,
    ST_DRAIN    = 4'd8
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage sitting after the program counter. Reads one byte per memory
// transaction at the current PC, assembles 1- or 2-byte instructions into the
// instruction register and offers them to the controller with valid/ready.
// Pulses pc_up once per byte fetched; a flush abandons the instruction in
// progress (an outstanding memory read is drained and its data discarded).
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   fetch_en            allows a new instruction fetch to start
//   flush               controller loads the PC this cycle; abandon work
//   pc_in               current PC value
//   pc_up               one-cycle PC increment request
//   mem_addr/mem_rd_req read address / request (held until acked)
//   mem_rd_ack/_data    read completion and data
//   ir_valid/ir_ready   instruction handshake with the controller
//   ir_opcode/operand   instruction bytes (operand 0 for 1-byte instructions)
//   ir_pc               address of the opcode byte
//   ir_len              0 = 1-byte, 1 = 2-byte instruction
// All outputs are registered.
// -----------------------------------------------------------------------------
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = CPU_ADDR_W,
  parameter int DATA_W      = CPU_DATA_W,
  parameter int LONG_OP_BIT = CPU_LONG_OP_BIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_up,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_req,
  input  logic              mem_rd_ack,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_opcode,
  output logic [DATA_W-1:0] ir_operand,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_len
);

  fetch_state_t      state_r;
  fetch_state_t      state_nxt_s;
  logic              pc_up_nxt_s;
  logic [ADDR_W-1:0] mem_addr_nxt_s;
  logic              mem_rd_req_nxt_s;
  logic              ir_valid_nxt_s;
  logic [DATA_W-1:0] ir_opcode_nxt_s;
  logic [DATA_W-1:0] ir_operand_nxt_s;
  logic [ADDR_W-1:0] ir_pc_nxt_s;
  logic              ir_len_nxt_s;

  // Next-state and next-output logic for the fetch sequencer.
  always_comb begin
    state_nxt_s      = state_r;
    pc_up_nxt_s      = 1'b0;
    mem_addr_nxt_s   = mem_addr;
    mem_rd_req_nxt_s = mem_rd_req;
    ir_valid_nxt_s   = ir_valid;
    ir_opcode_nxt_s  = ir_opcode;
    ir_operand_nxt_s = ir_operand;
    ir_pc_nxt_s      = ir_pc;
    ir_len_nxt_s     = ir_len;

    if (flush) begin
      // A flush overrides everything; any data acked this cycle is dropped
      // and no pc_up is issued for it.
      ir_valid_nxt_s = 1'b0;
      if (mem_rd_req && !mem_rd_ack) begin
        // The memory still owes us a response: keep the request up and
        // swallow the data when it arrives.
        state_nxt_s = ST_DRAIN;
      end else begin
        mem_rd_req_nxt_s = 1'b0;
        state_nxt_s      = fetch_en ? ST_REQ_OP : ST_IDLE;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (fetch_en) begin
            state_nxt_s = ST_REQ_OP;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_REQ_OP: begin
          mem_addr_nxt_s   = pc_in;
          ir_pc_nxt_s      = pc_in;
          mem_rd_req_nxt_s = 1'b1;
          state_nxt_s      = ST_WAIT_OP;
        end
        ST_WAIT_OP: begin
          if (mem_rd_ack) begin
            mem_rd_req_nxt_s = 1'b0;
            ir_opcode_nxt_s  = mem_rd_data;
            ir_len_nxt_s     = mem_rd_data[LONG_OP_BIT];
            ir_operand_nxt_s = '0;
            pc_up_nxt_s      = 1'b1;
            state_nxt_s      = ST_INC_OP;
          end else begin
            state_nxt_s = ST_WAIT_OP;
          end
        end
        ST_INC_OP: begin
          // pc_up is high during this cycle, so pc_in is the operand
          // address by the time REQ_ARG samples it.
          if (ir_len) begin
            state_nxt_s = ST_REQ_ARG;
          end else begin
            ir_valid_nxt_s = 1'b1;
            state_nxt_s    = ST_OUT;
          end
        end
        ST_REQ_ARG: begin
          mem_addr_nxt_s   = pc_in;
          mem_rd_req_nxt_s = 1'b1;
          state_nxt_s      = ST_WAIT_ARG;
        end
        ST_WAIT_ARG: begin
          if (mem_rd_ack) begin
            mem_rd_req_nxt_s = 1'b0;
            ir_operand_nxt_s = mem_rd_data;
            pc_up_nxt_s      = 1'b1;
            state_nxt_s      = ST_INC_ARG;
          end else begin
            state_nxt_s = ST_WAIT_ARG;
          end
        end
        ST_INC_ARG: begin
          ir_valid_nxt_s = 1'b1;
          state_nxt_s    = ST_OUT;
        end
        ST_OUT: begin
          if (ir_ready) begin
            ir_valid_nxt_s = 1'b0;
            state_nxt_s    = fetch_en ? ST_REQ_OP : ST_IDLE;
          end else begin
            state_nxt_s = ST_OUT;
          end
        end
        ST_DRAIN: begin
          if (mem_rd_ack) begin
            mem_rd_req_nxt_s = 1'b0;
            state_nxt_s      = fetch_en ? ST_REQ_OP : ST_IDLE;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end
        default: begin
          mem_rd_req_nxt_s = 1'b0;
          ir_valid_nxt_s   = 1'b0;
          state_nxt_s      = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset drops any outstanding request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      pc_up      <= 1'b0;
      mem_addr   <= '0;
      mem_rd_req <= 1'b0;
      ir_valid   <= 1'b0;
      ir_opcode  <= '0;
      ir_operand <= '0;
      ir_pc      <= '0;
      ir_len     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      pc_up      <= pc_up_nxt_s;
      mem_addr   <= mem_addr_nxt_s;
      mem_rd_req <= mem_rd_req_nxt_s;
      ir_valid   <= ir_valid_nxt_s;
      ir_opcode  <= ir_opcode_nxt_s;
      ir_operand <= ir_operand_nxt_s;
      ir_pc      <= ir_pc_nxt_s;
      ir_len     <= ir_len_nxt_s;
    end
  end

endmodule
